// File: rtl/io_controller_pkg.sv
// rtl/io_controller_pkg.sv - shared types and constants for the IN/OUT handshake controller
package io_controller_pkg;

   localparam int IO_DW               = 32;
   localparam int SW_DW               = 16;
   localparam int INSERT_CYCLES_DEF   = 6;
   localparam int DEBOUNCE_CYCLES_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_IN,
      WAIT_OUT,
      INSERT_IN,
      INSERT_OUT
   } state_t;

endpackage

// File: rtl/io_controller_debounce.sv
// rtl/io_controller_debounce.sv - button synchronizer, debounce filter and press-edge detector
module debounce
   import io_controller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic CLK,
   input  logic reset_n,
   input  logic button_raw,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_level_d;
   logic [CW-1:0] r_cnt;

   // The counter only runs while the synchronized sample disagrees with the accepted level,
   // so any bounce back to the old level restarts the qualification window.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= button_raw;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign press = r_level & ~r_level_d;

endmodule

// File: rtl/io_controller.sv
// rtl/io_controller.sv - stalls the PC on IN/OUT until a button press, then releases it
module io_controller
   import io_controller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int INSERT_CYCLES   = INSERT_CYCLES_DEF
) (
   input  logic             CLK,
   input  logic             reset_n,
   input  logic             in_instr,
   input  logic             out_instr,
   input  logic             button_raw,
   input  logic [SW_DW-1:0] switches,
   input  logic [IO_DW-1:0] out_data,
   output logic             input_flag,
   output logic             output_flag,
   output logic             insert,
   output logic [IO_DW-1:0] in_data,
   output logic             in_valid,
   output logic [IO_DW-1:0] display
);

   localparam int ICW = $clog2(INSERT_CYCLES + 1);

   state_t           r_state;
   state_t           w_next;
   logic [ICW-1:0]   r_ins_cnt;
   logic             w_press;
   logic             w_ins_last;
   logic             w_in_insert;
   logic [IO_DW-1:0] r_in_data;
   logic             r_in_valid;
   logic [IO_DW-1:0] r_display;

   debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .CLK       (CLK),
      .reset_n   (reset_n),
      .button_raw(button_raw),
      .press     (w_press)
   );

   assign w_in_insert = (r_state == INSERT_IN) || (r_state == INSERT_OUT);
   assign w_ins_last  = (r_ins_cnt == ICW'(INSERT_CYCLES - 1));

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (in_instr) begin
               w_next = WAIT_IN;
            end else if (out_instr) begin
               w_next = WAIT_OUT;
            end
         end
         WAIT_IN:    if (w_press) w_next = INSERT_IN;
         WAIT_OUT:   if (w_press) w_next = INSERT_OUT;
         INSERT_IN,
         INSERT_OUT: if (w_ins_last) w_next = IDLE;
         default:    w_next = IDLE;
      endcase
   end

   // The IDLE terms are combinational so the PC is stalled on the very cycle the decoder flags IN/OUT.
   always_comb begin
      input_flag  = 1'b0;
      output_flag = 1'b0;
      insert      = 1'b0;
      case (r_state)
         IDLE: begin
            input_flag  = in_instr;
            output_flag = out_instr & ~in_instr;
         end
         WAIT_IN:    input_flag = 1'b1;
         WAIT_OUT:   output_flag = 1'b1;
         INSERT_IN: begin
            input_flag = 1'b1;
            insert     = 1'b1;
         end
         INSERT_OUT: begin
            output_flag = 1'b1;
            insert      = 1'b1;
         end
         default: begin
            input_flag  = 1'b0;
            output_flag = 1'b0;
            insert      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_ins_cnt  <= '0;
         r_in_data  <= '0;
         r_in_valid <= 1'b0;
         r_display  <= '0;
      end else begin
         r_in_valid <= 1'b0;
         if (!w_in_insert) begin
            r_ins_cnt <= '0;
         end else if (!w_ins_last) begin
            r_ins_cnt <= r_ins_cnt + ICW'(1);
         end
         if (r_state == WAIT_IN && w_press) begin
            r_in_data  <= {{(IO_DW - SW_DW){1'b0}}, switches};
            r_in_valid <= 1'b1;
         end
         if (r_state == IDLE && !in_instr && out_instr) begin
            r_display <= out_data;
         end
      end
   end

   assign in_data  = r_in_data;
   assign in_valid = r_in_valid;
   assign display  = r_display;

endmodule

// File: tb/tb_io_controller.sv
// tb/tb_io_controller.sv - randomized self-checking bench for io_controller
module tb_io_controller;
   import io_controller_pkg::*;

   localparam int DEB = 4;
   localparam int INS = INSERT_CYCLES_DEF;

   logic        CLK = 1'b0;
   logic        reset_n;
   logic        in_instr;
   logic        out_instr;
   logic        button_raw;
   logic [15:0] switches;
   logic [31:0] out_data;
   logic        input_flag;
   logic        output_flag;
   logic        insert;
   logic [31:0] in_data;
   logic        in_valid;
   logic [31:0] display;

   int          n_vec = 0;
   int          n_err = 0;

   int          st_valid;
   int          st_ins;
   int          st_gap;
   bit          st_timeout;
   logic [31:0] st_data;
   logic [31:0] exp_display;

   io_controller #(
      .DEBOUNCE_CYCLES(DEB),
      .INSERT_CYCLES  (INS)
   ) dut (
      .CLK        (CLK),
      .reset_n    (reset_n),
      .in_instr   (in_instr),
      .out_instr  (out_instr),
      .button_raw (button_raw),
      .switches   (switches),
      .out_data   (out_data),
      .input_flag (input_flag),
      .output_flag(output_flag),
      .insert     (insert),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .display    (display)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic press_btn(input int pre, input int hold, input bit bouncy);
      repeat (pre) tick();
      if (bouncy) begin
         for (int i = 0; i < 10; i++) begin
            button_raw = ((i / 2) % 2 == 0);
            tick();
         end
      end
      button_raw = 1'b1;
      repeat (hold) tick();
      button_raw = 1'b0;
      repeat (10) tick();
   endtask

   // Observes one operation until the insert window closes; gathers statistics only.
   task automatic run_txn(input int budget, input bit clear_at_end);
      bit seen;
      seen       = 1'b0;
      st_valid   = 0;
      st_ins     = 0;
      st_gap     = 0;
      st_timeout = 1'b1;
      st_data    = 'x;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (in_valid) begin
            st_valid++;
            st_data = in_data;
         end
         if (insert) begin
            seen = 1'b1;
            st_ins++;
            if (!(input_flag || output_flag)) st_gap++;
         end else if (seen) begin
            st_timeout = 1'b0;
            if (clear_at_end) begin
               in_instr  = 1'b0;
               out_instr = 1'b0;
            end
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      in_instr   = 1'b0;
      out_instr  = 1'b0;
      button_raw = 1'b0;
      switches   = '0;
      out_data   = 32'h1111_2222;
      repeat (3) tick();
      n_vec += 6;
      if (input_flag !== 1'b0)  begin n_err++; $display("FAIL rst_input_flag got %b exp 0", input_flag); end
      if (output_flag !== 1'b0) begin n_err++; $display("FAIL rst_output_flag got %b exp 0", output_flag); end
      if (insert !== 1'b0)      begin n_err++; $display("FAIL rst_insert got %b exp 0", insert); end
      if (in_valid !== 1'b0)    begin n_err++; $display("FAIL rst_in_valid got %b exp 0", in_valid); end
      if (in_data !== 32'h0)    begin n_err++; $display("FAIL rst_in_data got %h exp 0", in_data); end
      if (display !== 32'h0)    begin n_err++; $display("FAIL rst_display got %h exp 0", display); end
      out_data  = 32'hCAFE_0001;
      out_instr = 1'b1;
      reset_n   = 1'b1;
      tick();
      exp_display = 32'hCAFE_0001;
      n_vec += 2;
      if (display !== exp_display) begin n_err++; $display("FAIL rst_first_edge_display got %h exp %h", display, exp_display); end
      if (output_flag !== 1'b1)    begin n_err++; $display("FAIL rst_first_edge_oflag got %b exp 1", output_flag); end
      fork
         press_btn(2, 8, 1'b0);
         run_txn(300, 1'b1);
      join
      n_vec += 2;
      if (st_timeout)    begin n_err++; $display("FAIL rst_out_txn timeout got 1 exp 0"); end
      if (st_valid !== 0) begin n_err++; $display("FAIL rst_out_valid got %0d exp 0", st_valid); end
   endtask

   task automatic test_in(input logic [15:0] sw, input bit bouncy);
      in_instr = 1'b1;
      switches = sw;
      #1;
      n_vec += 2;
      if (input_flag !== 1'b1)  begin n_err++; $display("FAIL in_flag_same_cycle got %b exp 1", input_flag); end
      if (output_flag !== 1'b0) begin n_err++; $display("FAIL in_oflag got %b exp 0", output_flag); end
      fork
         press_btn(5, 8, bouncy);
         run_txn(300, 1'b1);
      join
      #1;
      n_vec += 6;
      if (st_timeout)               begin n_err++; $display("FAIL in_txn timeout got 1 exp 0"); end
      if (st_valid !== 1)           begin n_err++; $display("FAIL in_valid_pulses got %0d exp 1", st_valid); end
      if (st_data !== {16'h0, sw})  begin n_err++; $display("FAIL in_data got %h exp %h", st_data, {16'h0, sw}); end
      if (st_ins !== INS)           begin n_err++; $display("FAIL in_insert_cycles got %0d exp %0d", st_ins, INS); end
      if (st_gap !== 0)             begin n_err++; $display("FAIL in_flag_during_insert gaps %0d exp 0", st_gap); end
      if (display !== exp_display)  begin n_err++; $display("FAIL in_display_held got %h exp %h", display, exp_display); end
   endtask

   task automatic test_out(input logic [31:0] d);
      out_instr = 1'b1;
      out_data  = d;
      #1;
      n_vec += 2;
      if (output_flag !== 1'b1) begin n_err++; $display("FAIL out_flag_same_cycle got %b exp 1", output_flag); end
      if (input_flag !== 1'b0)  begin n_err++; $display("FAIL out_iflag got %b exp 0", input_flag); end
      tick();
      exp_display = d;
      out_data    = ~d;
      n_vec++;
      if (display !== exp_display) begin n_err++; $display("FAIL out_display_load got %h exp %h", display, exp_display); end
      fork
         press_btn(3, 8, 1'b0);
         run_txn(300, 1'b1);
      join
      n_vec += 5;
      if (st_timeout)              begin n_err++; $display("FAIL out_txn timeout got 1 exp 0"); end
      if (st_valid !== 0)          begin n_err++; $display("FAIL out_valid_pulses got %0d exp 0", st_valid); end
      if (st_ins !== INS)          begin n_err++; $display("FAIL out_insert_cycles got %0d exp %0d", st_ins, INS); end
      if (st_gap !== 0)            begin n_err++; $display("FAIL out_flag_during_insert gaps %0d exp 0", st_gap); end
      if (display !== exp_display) begin n_err++; $display("FAIL out_display_hold got %h exp %h", display, exp_display); end
   endtask

   task automatic test_both();
      in_instr  = 1'b1;
      out_instr = 1'b1;
      switches  = 16'h5A5A;
      out_data  = 32'h0BAD_F00D;
      #1;
      n_vec += 2;
      if (input_flag !== 1'b1)  begin n_err++; $display("FAIL both_iflag got %b exp 1", input_flag); end
      if (output_flag !== 1'b0) begin n_err++; $display("FAIL both_oflag got %b exp 0", output_flag); end
      tick();
      n_vec += 2;
      if (output_flag !== 1'b0)    begin n_err++; $display("FAIL both_oflag_wait got %b exp 0", output_flag); end
      if (display !== exp_display) begin n_err++; $display("FAIL both_display got %h exp %h", display, exp_display); end
      fork
         press_btn(2, 8, 1'b0);
         run_txn(300, 1'b1);
      join
      n_vec += 2;
      if (st_valid !== 1)                 begin n_err++; $display("FAIL both_valid got %0d exp 1", st_valid); end
      if (st_data !== 32'h0000_5A5A)      begin n_err++; $display("FAIL both_data got %h exp 00005a5a", st_data); end
   endtask

   task automatic test_ignored();
      int v;
      int ins;
      in_instr  = 1'b0;
      out_instr = 1'b0;
      press_btn(0, 8, 1'b0);
      in_instr = 1'b1;
      switches = 16'h0F0F;
      v   = 0;
      ins = 0;
      repeat (30) begin
         tick();
         if (in_valid) v++;
         if (insert) ins++;
      end
      n_vec += 3;
      if (v !== 0)             begin n_err++; $display("FAIL idle_press_queued valid %0d exp 0", v); end
      if (ins !== 0)           begin n_err++; $display("FAIL idle_press_queued insert %0d exp 0", ins); end
      if (input_flag !== 1'b1) begin n_err++; $display("FAIL idle_press_wait_flag got %b exp 1", input_flag); end
      fork
         press_btn(0, 8, 1'b0);
         run_txn(300, 1'b1);
      join
      n_vec++;
      if (st_valid !== 1) begin n_err++; $display("FAIL idle_press_followup got %0d exp 1", st_valid); end
   endtask

   task automatic test_held();
      int v;
      int ins;
      in_instr   = 1'b1;
      switches   = 16'h00AA;
      button_raw = 1'b1;
      run_txn(300, 1'b0);
      n_vec += 2;
      if (st_valid !== 1)            begin n_err++; $display("FAIL held_first_valid got %0d exp 1", st_valid); end
      if (st_data !== 32'h0000_00AA) begin n_err++; $display("FAIL held_first_data got %h exp 000000aa", st_data); end
      switches = 16'h0055;
      v   = 0;
      ins = 0;
      repeat (40) begin
         tick();
         if (in_valid) v++;
         if (insert) ins++;
      end
      n_vec += 3;
      if (v !== 0)             begin n_err++; $display("FAIL held_second_valid got %0d exp 0", v); end
      if (ins !== 0)           begin n_err++; $display("FAIL held_second_insert got %0d exp 0", ins); end
      if (input_flag !== 1'b1) begin n_err++; $display("FAIL held_second_stall got %b exp 1", input_flag); end
      button_raw = 1'b0;
      repeat (10) tick();
      fork
         press_btn(0, 8, 1'b0);
         run_txn(300, 1'b1);
      join
      n_vec += 2;
      if (st_valid !== 1)            begin n_err++; $display("FAIL held_repress_valid got %0d exp 1", st_valid); end
      if (st_data !== 32'h0000_0055) begin n_err++; $display("FAIL held_repress_data got %h exp 00000055", st_data); end
   endtask

   task automatic test_reset_mid_insert();
      int k;
      int c;
      int v;
      int ins;
      in_instr = 1'b1;
      switches = 16'h1234;
      k = 0;
      c = 0;
      fork
         press_btn(2, 8, 1'b0);
         begin
            while (k < 3 && c < 300) begin
               tick();
               if (insert) k++;
               c++;
            end
            n_vec++;
            if (k < 3) begin n_err++; $display("FAIL rstmid_reach_insert got %0d exp 3", k); end
            #2;
            reset_n  = 1'b0;
            in_instr = 1'b0;
            #1;
            n_vec += 6;
            if (insert !== 1'b0)      begin n_err++; $display("FAIL rstmid_insert got %b exp 0", insert); end
            if (input_flag !== 1'b0)  begin n_err++; $display("FAIL rstmid_iflag got %b exp 0", input_flag); end
            if (output_flag !== 1'b0) begin n_err++; $display("FAIL rstmid_oflag got %b exp 0", output_flag); end
            if (in_valid !== 1'b0)    begin n_err++; $display("FAIL rstmid_valid got %b exp 0", in_valid); end
            if (in_data !== 32'h0)    begin n_err++; $display("FAIL rstmid_in_data got %h exp 0", in_data); end
            if (display !== 32'h0)    begin n_err++; $display("FAIL rstmid_display got %h exp 0", display); end
         end
      join
      exp_display = 32'h0;
      tick();
      reset_n = 1'b1;
      v   = 0;
      ins = 0;
      repeat (20) begin
         tick();
         if (in_valid) v++;
         if (insert) ins++;
      end
      n_vec += 2;
      if (ins !== 0) begin n_err++; $display("FAIL rstmid_no_insert got %0d exp 0", ins); end
      if (v !== 0)   begin n_err++; $display("FAIL rstmid_no_valid got %0d exp 0", v); end
   endtask

   task automatic test_random(input int n);
      int          kind;
      logic [15:0] sw;
      logic [31:0] d;
      bit          is_in;
      for (int t = 0; t < n; t++) begin
         kind  = $urandom_range(0, 2);
         sw    = 16'($urandom);
         d     = $urandom;
         is_in = (kind != 1);
         switches  = sw;
         out_data  = d;
         in_instr  = is_in;
         out_instr = (kind != 0);
         if (!is_in) exp_display = d;
         #1;
         n_vec += 2;
         if (input_flag !== is_in)   begin n_err++; $display("FAIL rnd%0d_iflag got %b exp %b", t, input_flag, is_in); end
         if (output_flag !== !is_in) begin n_err++; $display("FAIL rnd%0d_oflag got %b exp %b", t, output_flag, !is_in); end
         fork
            press_btn($urandom_range(0, 8), $urandom_range(6, 12), 1'($urandom_range(0, 1)));
            run_txn(400, 1'b1);
         join
         n_vec += 4;
         if (st_timeout)                 begin n_err++; $display("FAIL rnd%0d_timeout got 1 exp 0", t); end
         if (st_valid !== int'(is_in))   begin n_err++; $display("FAIL rnd%0d_valid got %0d exp %0d", t, st_valid, is_in); end
         if (st_ins !== INS)             begin n_err++; $display("FAIL rnd%0d_insert got %0d exp %0d", t, st_ins, INS); end
         if (display !== exp_display)    begin n_err++; $display("FAIL rnd%0d_display got %h exp %h", t, display, exp_display); end
         if (is_in) begin
            n_vec++;
            if (st_data !== {16'h0, sw}) begin n_err++; $display("FAIL rnd%0d_data got %h exp %h", t, st_data, {16'h0, sw}); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_in(16'h00A5, 1'b0);
      test_out(32'hDEAD_BEEF);
      test_in(16'hBEEF, 1'b1);
      test_both();
      test_ignored();
      test_held();
      test_reset_mid_insert();
      test_random(10);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/io_controller.md
IO_CONTROLLER -- requirements
Module: io_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples before the button level is accepted.
REQ-002 Parameter INSERT_CYCLES, default 6, number of cycles insert is held high; this matches the program-counter release count of 5 hold cycles plus 1 load cycle.
REQ-003 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_instr  input  1  level from the decoder: the current instruction is IN.
REQ-006 out_instr  input  1  level from the decoder: the current instruction is OUT.
REQ-007 button_raw  input  1  asynchronous, bouncy user confirm button, active-high.
REQ-008 switches  input  16  user data switches.
REQ-009 out_data  input  32  register value to display for OUT.
REQ-010 input_flag  output  1  stall request to the program counter for IN.
REQ-011 output_flag  output  1  stall request to the program counter for OUT.
REQ-012 insert  output  1  release request to the program counter.
REQ-013 in_data  output  32  captured switch value for register write-back.
REQ-014 in_valid  output  1  one-cycle write-enable for in_data.
REQ-015 display  output  32  latched value shown on the display.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_IN, WAIT_OUT, INSERT_IN and INSERT_OUT.
REQ-017 input_flag SHALL equal (IDLE and in_instr) or state in {WAIT_IN, INSERT_IN}; the term in IDLE is combinational so that the program counter never advances past an IN instruction.
REQ-018 output_flag SHALL equal (IDLE and out_instr and not in_instr) or state in {WAIT_OUT, INSERT_OUT}.
REQ-019 IDLE transitions: to WAIT_IN if in_instr; else to WAIT_OUT if out_instr; in_instr SHALL take priority when both are high.
REQ-020 On the IDLE->WAIT_OUT edge, display SHALL load out_data.
REQ-021 The button path SHALL be:
  - a 2-flop synchronizer;
  - a debounce counter that accepts a new level only after DEBOUNCE_CYCLES consecutive equal samples;
  - a rising-edge detector producing a one-cycle press pulse.
REQ-022 Press in WAIT_IN SHALL:
  - load in_data with switches zero-extended to 32 bits;
  - pulse in_valid for exactly 1 cycle;
  - transition to INSERT_IN.
REQ-023 Press in WAIT_OUT SHALL transition to INSERT_OUT; display SHALL be held.
REQ-024 Press in IDLE, INSERT_IN or INSERT_OUT SHALL be ignored and SHALL NOT be queued.
REQ-025 In INSERT_x, insert SHALL be high for exactly INSERT_CYCLES consecutive cycles.
REQ-026 In INSERT_x, the corresponding flag SHALL stay high through the final insert cycle.
REQ-027 After the final insert cycle the FSM SHALL return to IDLE.
REQ-028 The insert-cycle counter SHALL be ceil(log2(INSERT_CYCLES+1)) bits wide, SHALL clear on entry to INSERT_x, and SHALL never wrap.
REQ-029 On the cycle after INSERT_x returns to IDLE, the FSM SHALL evaluate in_instr/out_instr afresh, so that back-to-back IN/OUT instructions each require their own press.
REQ-030 A button held high across an entire IN SHALL NOT confirm the next IN; a release followed by a new debounced press SHALL be required.
REQ-031 display SHALL change only on IDLE->WAIT_OUT or on reset.

Reset
REQ-032 reset_n low SHALL asynchronously force:
  - state to IDLE;
  - input_flag, output_flag (registered part), insert and in_valid to 0;
  - in_data and display to 0;
  - the debounce counter, the synchronizer, the debounced level and the insert counter to 0.
REQ-033 Reset asserted mid-WAIT or mid-INSERT SHALL abort the operation with no in_valid pulse.
REQ-034 After reset deassertion, the first rising edge of CLK SHALL be able to leave IDLE.

Structure
REQ-035 A shared package SHALL hold:
  - the state enumeration;
  - the INSERT_CYCLES default;
  - the IO data width constant 32.
REQ-036 Sub-module debounce SHALL contain the synchronizer, debounce counter and edge detector, with output press.
REQ-037 io_controller SHALL instantiate debounce once and SHALL contain the FSM, the insert counter and the data latches.

Verification (DEBOUNCE_CYCLES=4)
REQ-038 IN, in_instr=1, switches=16'h00A5, clean press -> input_flag high the same cycle; in_data=32'h000000A5; in_valid for 1 cycle; insert high for 6 cycles; then IDLE.
REQ-039 OUT, out_data=32'hDEADBEEF -> display=32'hDEADBEEF one cycle after detection; output_flag held until press plus 6 insert cycles; in_valid never pulses.
REQ-040 Bouncy press (toggles every 2 cycles for 10 cycles, then stable high) in WAIT_IN -> exactly one in_valid pulse.
REQ-041 in_instr=1 and out_instr=1 together -> WAIT_IN; output_flag stays 0.
REQ-042 reset_n low on the 3rd insert cycle -> all outputs 0 asynchronously; no further insert.
REQ-043 Button held high through two back-to-back IN instructions -> the second IN stays in WAIT_IN until release and a new press.
